// File: rtl/ex_stage_sequencer_pkg.sv
// Shared definitions for the EX stage: OF packet layout, opcodes, ctrl bits, FSM states.
package ex_pkg;

  localparam int unsigned CTRL_LSB = 0;
  localparam int unsigned CTRL_W   = 8;
  localparam int unsigned PC_LSB   = 8;
  localparam int unsigned PC_W     = 8;
  localparam int unsigned OP1_LSB  = 16;
  localparam int unsigned OP_W     = 64;
  localparam int unsigned OP2_LSB  = 80;
  localparam int unsigned FLAG_BIT = 144;
  localparam int unsigned ADDR_LSB = 145;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned REG_LSB  = 153;
  localparam int unsigned REG_W    = 4;

  localparam logic [2:0] OPC_ADD = 3'b001;
  localparam logic [2:0] OPC_MUL = 3'b010;
  localparam logic [2:0] OPC_INC = 3'b011;
  localparam logic [2:0] OPC_XOR = 3'b100;
  localparam logic [2:0] OPC_CMP = 3'b110;

  localparam int unsigned CTRL_CBR   = 3;
  localparam int unsigned CTRL_UBR   = 7;
  localparam int unsigned CTRL_WB_HI = 6;
  localparam int unsigned CTRL_WB_LO = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_READY
  } ex_state_e;

  function automatic logic is_mul(input logic [CTRL_W-1:0] ctrl);
    return ctrl[2:0] == OPC_MUL;
  endfunction

endpackage

// File: rtl/ex_stage_sequencer_alu.sv
// Combinational execute datapath: result packet toward MEM and {taken, PC+addr} branch info.
module alu
  import ex_pkg::*;
(
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [OP_W-1:0]   op1_i,
  input  logic [OP_W-1:0]   op2_i,
  input  logic              flag_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [REG_W-1:0]  reg_i,
  output logic [78:0]       res_o,
  output logic [8:0]        branch_o
);

  logic [OP_W-1:0] value;

  always_comb begin
    value = '0;
    case (ctrl_i[2:0])
      OPC_ADD: value = op1_i + op2_i;
      OPC_MUL: value = op1_i * op2_i;
      OPC_INC: value = op1_i + 64'd1;
      OPC_XOR: value = op1_i ^ op2_i;
      OPC_CMP: value = {63'd0, op1_i == op2_i};
      default: value = '0;
    endcase
  end

  assign res_o    = {reg_i, ctrl_i[CTRL_WB_HI:CTRL_WB_LO], value, addr_i};
  assign branch_o = {(ctrl_i[CTRL_CBR] & flag_i) | ctrl_i[CTRL_UBR], pc_i + addr_i};

endmodule

// File: rtl/ex_stage_sequencer.sv
// EX stage sequencer around the alu: multi-cycle multiply, MEM backpressure, branch redirect.
// Optional stall counter port stall_cycles is built when EX_STALL_CNT_EN is defined.
module ex_stage_sequencer
  import ex_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned PKT_W      = 157,
  parameter int unsigned OUT_W      = 79
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_pkt,
  output logic             redirect_valid,
  output logic [7:0]       redirect_pc,
  output logic             flush
`ifdef EX_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 1);
  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);

  ex_state_e        state_q, state_d;
  logic [PKT_W-1:0] ex_q, ex_d;
  logic             ex_valid_q, ex_valid_d;
  logic [3:0]       mul_cnt_q, mul_cnt_d;
  logic             redir_q, redir_d;
  logic [7:0]       redir_pc_q, redir_pc_d;

  logic [8:0]       branch;
  logic             taken;
  logic             accept;
  logic             fire;
  logic             in_is_mul;

  alu u_alu (
    .ctrl_i   (ex_q[CTRL_LSB +: CTRL_W]),
    .pc_i     (ex_q[PC_LSB +: PC_W]),
    .op1_i    (ex_q[OP1_LSB +: OP_W]),
    .op2_i    (ex_q[OP2_LSB +: OP_W]),
    .flag_i   (ex_q[FLAG_BIT]),
    .addr_i   (ex_q[ADDR_LSB +: ADDR_W]),
    .reg_i    (ex_q[REG_LSB +: REG_W]),
    .res_o    (out_pkt),
    .branch_o (branch)
  );

  assign taken     = branch[8];
  assign out_valid = (state_q == S_READY) && ex_valid_q;
  // A taken branch must not pull in the wrong-path packet on its own fire cycle.
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_READY) && out_ready && !taken);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign in_is_mul = is_mul(in_pkt[CTRL_LSB +: CTRL_W]);

  always_comb begin
    state_d    = state_q;
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    mul_cnt_d  = mul_cnt_q;
    redir_d    = 1'b0;
    redir_pc_d = redir_pc_q;

    case (state_q)
      S_IDLE: ;
      S_MUL_WAIT: begin
        if (mul_cnt_q <= 4'd1) begin
          mul_cnt_d = '0;
          state_d   = S_READY;
        end else begin
          mul_cnt_d = mul_cnt_q - 4'd1;
        end
      end
      S_READY: begin
        if (fire) begin
          state_d    = S_IDLE;
          ex_valid_d = 1'b0;
          if (taken) begin
            redir_d    = 1'b1;
            redir_pc_d = branch[7:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An accept overrides the fire-to-IDLE transition, giving back-to-back issue.
    if (accept) begin
      ex_d       = in_pkt;
      ex_valid_d = 1'b1;
      if (in_is_mul && MUL_MULTI) begin
        state_d   = S_MUL_WAIT;
        mul_cnt_d = MUL_LOAD;
      end else begin
        state_d   = S_READY;
        mul_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      mul_cnt_q  <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      mul_cnt_q  <= mul_cnt_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign redirect_valid = redir_q;
  assign flush          = redir_q;
  assign redirect_pc    = redir_pc_q;

`ifdef EX_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == S_MUL_WAIT) || (out_valid && !out_ready)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ex_stage_sequencer.sv
// Randomized and directed bench for ex_stage_sequencer against a transaction-level reference model.
module tb_ex_stage_sequencer;

  localparam int unsigned MULC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [156:0] in_pkt;
  logic         out_valid;
  logic         out_ready;
  logic [78:0]  out_pkt;
  logic         redirect_valid;
  logic [7:0]   redirect_pc;
  logic         flush;
`ifdef EX_STALL_CNT_EN
  logic [31:0]  stall_cycles;
`endif

  always #5 clk = ~clk;

  ex_stage_sequencer #(.MUL_CYCLES(MULC)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pkt         (in_pkt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pkt        (out_pkt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
`ifdef EX_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one slot, a countdown of cycles until the result is visible.
  bit           m_occ;
  logic [156:0] m_pkt;
  int unsigned  m_left;
  bit           m_redir;
  logic [7:0]   m_rpc;
  logic [31:0]  m_stall;

  logic         s_in_ready, s_out_valid, s_redir, s_flush;
  logic [78:0]  s_out_pkt;
  logic [7:0]   s_rpc;
  logic [31:0]  s_stall;

  function automatic logic [156:0] mkpkt(input logic [3:0] rd, input logic [7:0] addr,
                                         input logic flag, input logic [63:0] op2,
                                         input logic [63:0] op1, input logic [7:0] pc,
                                         input logic [7:0] ctrl);
    return {rd, addr, flag, op2, op1, pc, ctrl};
  endfunction

  function automatic logic [63:0] ref_value(input logic [156:0] p);
    logic [63:0] a;
    logic [63:0] b;
    a = p[79:16];
    b = p[143:80];
    case (p[2:0])
      3'b001:  return a + b;
      3'b010:  return a * b;
      3'b011:  return a + 64'd1;
      3'b100:  return a ^ b;
      3'b110:  return (a == b) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [78:0] ref_out(input logic [156:0] p);
    return {p[156:153], p[6:4], ref_value(p), p[152:145]};
  endfunction

  function automatic bit ref_taken(input logic [156:0] p);
    return (p[3] & p[144]) | p[7];
  endfunction

  task automatic model_clear();
    m_occ   = 1'b0;
    m_pkt   = '0;
    m_left  = 0;
    m_redir = 1'b0;
    m_rpc   = 8'h00;
    m_stall = 32'd0;
  endtask

  task automatic step(input bit r, input bit v, input logic [156:0] p, input bit ordy);
    bit e_valid, e_taken, e_ready, acc, fr;
    rst       = r;
    in_valid  = v;
    in_pkt    = p;
    out_ready = ordy;
    @(negedge clk);
    e_valid = m_occ && (m_left == 0);
    e_taken = m_occ && ref_taken(m_pkt);
    e_ready = !m_occ || (e_valid && ordy && !e_taken);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_pkt   = out_pkt;
    s_redir     = redirect_valid;
    s_flush     = flush;
    s_rpc       = redirect_pc;
    check_eq("in_ready", 80'(in_ready), 80'(e_ready));
    check_eq("out_valid", 80'(out_valid), 80'(e_valid));
    check_eq("redirect_valid", 80'(redirect_valid), 80'(m_redir));
    check_eq("flush", 80'(flush), 80'(m_redir));
    check_eq("redirect_pc", 80'(redirect_pc), 80'(m_rpc));
    if (e_valid) check_eq("out_pkt", 80'(out_pkt), 80'(ref_out(m_pkt)));
`ifdef EX_STALL_CNT_EN
    s_stall = stall_cycles;
    check_eq("stall_cycles", 80'(stall_cycles), 80'(m_stall));
`else
    s_stall = 32'd0;
`endif
    @(posedge clk);
    if (r) begin
      model_clear();
    end else begin
      acc = v && e_ready;
      fr  = e_valid && ordy;
      if (m_occ && ((m_left > 0) || (e_valid && !ordy))) m_stall = m_stall + 32'd1;
      m_redir = fr && e_taken;
      if (m_redir) m_rpc = 8'((m_pkt[15:8] + m_pkt[152:145]) % 256);
      if (fr) m_occ = 1'b0;
      else if (m_occ && (m_left > 0)) m_left = m_left - 1;
      if (acc) begin
        m_occ  = 1'b1;
        m_pkt  = p;
        m_left = (p[2:0] == 3'b010) ? MULC - 1 : 0;
      end
    end
    #1;
  endtask

  logic [156:0] p_add, p_mul, p_add2, p_inc, p_br, p_brn, p_cmp_eq, p_cmp_ne, p_junk, rp;
  logic [31:0]  stall_base;
  logic [7:0]   rctrl;
  logic [63:0]  rop1, rop2;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pkt = '0; out_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;

    p_add    = mkpkt(4'hD, 8'h11, 1'b0, 64'd1, 64'd3, 8'h20, 8'h51);
    p_mul    = mkpkt(4'h2, 8'h00, 1'b0, 64'd5, 64'd3, 8'h00, 8'h52);
    p_add2   = mkpkt(4'h3, 8'h04, 1'b0, 64'd10, 64'd20, 8'h00, 8'h01);
    p_inc    = mkpkt(4'h1, 8'h07, 1'b0, 64'd0, 64'd7, 8'h00, 8'h13);
    p_br     = mkpkt(4'h0, 8'h0D, 1'b1, 64'd0, 64'd0, 8'hFC, 8'h08);
    p_brn    = mkpkt(4'h0, 8'h0D, 1'b0, 64'd0, 64'd0, 8'hFC, 8'h08);
    p_cmp_eq = mkpkt(4'h4, 8'h00, 1'b0, 64'h5A, 64'h5A, 8'h00, 8'h06);
    p_cmp_ne = mkpkt(4'h5, 8'h00, 1'b0, 64'h5B, 64'h5A, 8'h00, 8'h06);
    p_junk   = mkpkt(4'hF, 8'hFF, 1'b1, 64'hDEAD, 64'hBEEF, 8'h00, 8'h01);

    // reset state
    step(0, 0, '0, 1);
    check_eq("rst_in_ready", 80'(s_in_ready), 80'd1);
    check_eq("rst_out_valid", 80'(s_out_valid), 80'd0);
    check_eq("rst_redirect_pc", 80'(s_rpc), 80'd0);

    // ADD
    step(0, 1, p_add, 1);
    step(0, 0, '0, 1);
    check_eq("add_valid", 80'(s_out_valid), 80'd1);
    check_eq("add_value", 80'(s_out_pkt[71:8]), 80'd4);
    check_eq("add_reg", 80'(s_out_pkt[78:75]), 80'hD);
    check_eq("add_wb", 80'(s_out_pkt[74:72]), 80'b101);

    // MUL with a held ADD behind it
    step(0, 1, p_mul, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, p_add2, 1);
      check_eq("mul_wait_in_ready", 80'(s_in_ready), 80'd0);
    end
    step(0, 1, p_add2, 1);
    check_eq("mul_valid", 80'(s_out_valid), 80'd1);
    check_eq("mul_value", 80'(s_out_pkt[71:8]), 80'd15);
    check_eq("mul_b2b_ready", 80'(s_in_ready), 80'd1);
    step(0, 0, '0, 1);
    check_eq("add2_value", 80'(s_out_pkt[71:8]), 80'd30);

    // backpressure
    step(0, 1, p_inc, 1);
    stall_base = m_stall;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, p_add, 0);
      check_eq("bp_value", 80'(s_out_pkt[71:8]), 80'd8);
      check_eq("bp_in_ready", 80'(s_in_ready), 80'd0);
    end
    step(0, 0, '0, 1);
    check_eq("bp_fire_valid", 80'(s_out_valid), 80'd1);
`ifdef EX_STALL_CNT_EN
    check_eq("bp_stall_cnt", 80'(s_stall - stall_base), 80'd3);
`endif

    // taken branch, wrapping target
    step(0, 1, p_br, 1);
    step(0, 1, p_junk, 1);
    check_eq("br_fire_in_ready", 80'(s_in_ready), 80'd0);
    step(0, 0, '0, 1);
    check_eq("br_redirect", 80'(s_redir), 80'd1);
    check_eq("br_flush", 80'(s_flush), 80'd1);
    check_eq("br_target", 80'(s_rpc), 80'h09);
    step(0, 0, '0, 1);
    check_eq("br_pulse_once", 80'(s_redir), 80'd0);

    // not-taken branch
    step(0, 1, p_brn, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    check_eq("brn_no_redirect", 80'(s_redir), 80'd0);

    // stalled taken branch produces exactly one redirect
    step(0, 1, p_br, 1);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    check_eq("br_stall_no_redir", 80'(s_redir), 80'd0);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    check_eq("br_stall_redir", 80'(s_redir), 80'd1);

    // CMP back-to-back
    step(0, 1, p_cmp_eq, 1);
    step(0, 1, p_cmp_ne, 1);
    check_eq("cmp_eq_value", 80'(s_out_pkt[71:8]), 80'd1);
    step(0, 0, '0, 1);
    check_eq("cmp_ne_value", 80'(s_out_pkt[71:8]), 80'd0);
    check_eq("cmp_b2b_valid", 80'(s_out_valid), 80'd1);

    // reset mid-multiply
    step(0, 1, p_mul, 1);
    step(0, 0, '0, 1);
    step(1, 0, '0, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, '0, 1);
      check_eq("rst_mul_no_out", 80'(s_out_valid), 80'd0);
    end
    check_eq("rst_mul_in_ready", 80'(s_in_ready), 80'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rctrl    = 8'($urandom);
      rctrl[7] = ($urandom_range(0, 9) == 0);
      rctrl[3] = ($urandom_range(0, 3) == 0);
      rop1     = {$urandom, $urandom};
      rop2     = ($urandom_range(0, 3) == 0) ? rop1 : {$urandom, $urandom};
      rp       = mkpkt(4'($urandom), 8'($urandom), 1'($urandom), rop2, rop1,
                       8'($urandom), rctrl);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, rp,
           $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
